printer_job_scheduler: RTL and testbench
========================================

# printer_job_scheduler

Schedules the shared printer between three requesters: boss, eng and boy. It picks the next job in round-robin order and latches that job's page count. It holds the printer grant for the whole job, paced at a fixed number of cycles per page, then frees it for one gap cycle. It sits between the requester logic and the printer datapath. Its `printer` code uses the same 2-bit encoding as the existing round-robin arbiter.

## Interface
- `PAGE_CYCLES`, default 4: clock cycles per printed page, legal range ≥1.
- `PAGE_W`, default 4: width of the page-count inputs and the internal page counter.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `req_boss`, `req_eng`, `req_boy` input, 1 each: request level, held high for the whole job.
- `pages_boss`, `pages_eng`, `pages_boy` input, `PAGE_W` each: job length in pages, sampled only at grant.
- `printer` output, 2: current owner.
  - 00 = idle.
  - 01 = boss.
  - 10 = eng.
  - 11 = boy.
- `busy` output, 1: high whenever `printer != 00`.
- `page_tick` output, 1: one-cycle pulse on the last cycle of each page.
- `done` output, 1: one-cycle pulse on the last cycle of a completed job.
- `abort` output, 1: one-cycle pulse when the owner drops its request mid-job.

## Operation
- States:
  - IDLE: no owner.
  - PRINT: job in progress.
  - GAP: forced one-cycle idle between jobs.
- Reset values:
  - state = IDLE.
  - `printer` = 00.
  - `busy`, `page_tick`, `done`, `abort` = 0.
  - Page counter and cycle counter = 0.
  - Last-winner pointer = boy, so boss has first priority after reset.
- IDLE, all requests low: stay in IDLE.
- IDLE, any request high:
  - Pick the first requester after the last winner, in cyclic order boss → eng → boy → boss.
  - Load the winner's pages into the page counter. A page count of 0 is treated as 1.
  - Clear the cycle counter, update the last-winner pointer and go to PRINT.
- PRINT:
  - The cycle counter counts 0 … `PAGE_CYCLES-1`.
  - At `PAGE_CYCLES-1`: pulse `page_tick`, reset the cycle counter and decrement the page counter.
  - On the page where the page counter equals 1: pulse `done` together with `page_tick`, then go to GAP.
  - If the owner's request is low in any PRINT cycle:
    - Pulse `abort` that cycle and go to GAP.
    - `page_tick` and `done` stay 0 that cycle.
- GAP: `printer` = 00 for exactly one cycle, then go to IDLE.
- Requests from non-owners are ignored during PRINT and GAP.
- `pages_*` inputs are ignored outside the grant cycle.
- Round-robin fairness: with all three requesting continuously, owners rotate boss, eng, boy, boss, …
- Width rules:
  - Cycle counter width is `$clog2(PAGE_CYCLES)`, minimum 1.
  - The page counter never wraps below 0.

## Timing
- `printer` is registered. A request first seen high at rising edge N gives a non-zero `printer` from edge N onward, i.e. visible in cycle N+1.
- Job with P pages (P ≥ 1):
  - `printer` is non-zero for exactly P×`PAGE_CYCLES` cycles.
  - `done` and the last `page_tick` are high in the final cycle of that window.
- GAP: after the job window, `printer` = 00 for one cycle.
  - The earliest next grant is visible 2 cycles after the last owner cycle: the GAP cycle, then the IDLE decision edge.
- `page_tick`, `done` and `abort` are combinational decodes of registered state. They are valid in the same cycle as the corresponding `printer` value.
- Abort: if the owner's request is low during a PRINT cycle, `abort` is high in that cycle and `printer` is 00 from the next edge (GAP).
- `rst` low at any time, including mid-job:
  - All state and outputs clear immediately, with no `done` or `abort` pulse.
  - The pointer returns to boy.
  - The first arbitration happens on the first rising edge after `rst` goes high.

## Structure
- Package `printer_pkg` holds:
  - Owner codes `PRN_IDLE`, `PRN_BOSS`, `PRN_ENG`, `PRN_BOY`.
  - The state typedef: `ST_IDLE`, `ST_PRINT`, `ST_GAP`.
- Sub-module `rr_pick3`: purely combinational.
  - Inputs: 3-bit request vector and 2-bit last-winner code.
  - Outputs: 2-bit winner code and a valid bit.
  - Reused by the top FSM and testable standalone.
- The top level holds:
  - The FSM.
  - The cycle and page counters.
  - The last-winner register.
  - A page-count mux driven by the winner code.

## Test plan
- **Reset and single job:** release reset with `PAGE_CYCLES`=4; raise `req_eng` with `pages_eng`=3 and hold it.
  - `printer`=10 for 12 cycles.
  - `page_tick` pulses at cycles 4, 8 and 12, with `done` at cycle 12.
  - Then 1 cycle of 00, then 10 again.
- **Rotation:** hold all three requests high with pages=1 each.
  - Owners are 01, 10, 11, 01, each for 4 cycles, separated by one 00 gap cycle.
  - `done` pulses once per job.
- **Zero-page job:** `req_boy` with `pages_boy`=0.
  - `printer`=11 for 4 cycles, with one `page_tick` and one `done`.
- **Abort:** `req_boss` with 5 pages; drop the request in cycle 6.
  - `abort` pulses in cycle 6 and `done` never pulses.
  - `printer`=00 from cycle 7; the next requester (eng, if requesting) is granted 2 cycles after `abort`.
- **Reset mid-job:** assert `rst` low during page 2 of an eng job.
  - All outputs are 0 immediately.
  - After release, with boss and eng both requesting, boss wins first (pointer reset).
- **Page-count sampling:** change `pages_boss` from 2 to 7 one cycle after the boss grant.
  - The job still lasts 2×`PAGE_CYCLES` cycles.

Source files
------------

// File: rtl/printer_pkg.sv
// Shared owner codes, FSM state type and request helper for the printer job scheduler.
package printer_pkg;

  localparam logic [1:0] PRN_IDLE = 2'b00;
  localparam logic [1:0] PRN_BOSS = 2'b01;
  localparam logic [1:0] PRN_ENG  = 2'b10;
  localparam logic [1:0] PRN_BOY  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRINT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Request level of whichever requester the owner code names (bit 0 = boss).
  function automatic logic owner_req(input logic [2:0] req, input logic [1:0] code);
    logic r;
    r = 1'b0;
    case (code)
      PRN_BOSS: r = req[0];
      PRN_ENG:  r = req[1];
      PRN_BOY:  r = req[2];
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin pick: first requester after the last winner, cyclic boss->eng->boy.
module rr_pick3
  import printer_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  always_comb begin
    winner = PRN_IDLE;
    valid  = |req;
    case (last)
      PRN_BOSS: begin
        if (req[1])      winner = PRN_ENG;
        else if (req[2]) winner = PRN_BOY;
        else if (req[0]) winner = PRN_BOSS;
      end
      PRN_ENG: begin
        if (req[2])      winner = PRN_BOY;
        else if (req[0]) winner = PRN_BOSS;
        else if (req[1]) winner = PRN_ENG;
      end
      // boy (and the unused idle code) hand first priority to boss
      default: begin
        if (req[0])      winner = PRN_BOSS;
        else if (req[1]) winner = PRN_ENG;
        else if (req[2]) winner = PRN_BOY;
      end
    endcase
  end

endmodule

// File: rtl/printer_job_scheduler.sv
// Grants the shared printer round-robin, holds it for pages*PAGE_CYCLES cycles,
// then forces a single idle cycle before the next grant.
module printer_job_scheduler
  import printer_pkg::*;
#(
  parameter int unsigned PAGE_CYCLES = 4,
  parameter int unsigned PAGE_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_boss,
  input  logic              req_eng,
  input  logic              req_boy,
  input  logic [PAGE_W-1:0] pages_boss,
  input  logic [PAGE_W-1:0] pages_eng,
  input  logic [PAGE_W-1:0] pages_boy,
  output logic [1:0]        printer,
  output logic              busy,
  output logic              page_tick,
  output logic              done,
  output logic              abort
);

  localparam int unsigned CYC_W = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(PAGE_CYCLES - 1);
  localparam logic [PAGE_W-1:0] PAGE_ONE = PAGE_W'(1);

  state_t            state_q, state_d;
  logic [1:0]        printer_q, printer_d;
  logic [1:0]        last_q, last_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;

  logic [2:0]        req_vec;
  logic [1:0]        win;
  logic              win_valid;
  logic [PAGE_W-1:0] win_pages;
  logic              owner_ok;

  assign req_vec  = {req_boy, req_eng, req_boss};
  assign owner_ok = owner_req(req_vec, printer_q);

  rr_pick3 u_pick (
    .req    (req_vec),
    .last   (last_q),
    .winner (win),
    .valid  (win_valid)
  );

  // Page count of the candidate winner, only consumed on the grant edge.
  always_comb begin
    win_pages = '0;
    case (win)
      PRN_BOSS: win_pages = pages_boss;
      PRN_ENG:  win_pages = pages_eng;
      PRN_BOY:  win_pages = pages_boy;
      default:  win_pages = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      printer_q <= PRN_IDLE;
      last_q    <= PRN_BOY;
      page_q    <= '0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      printer_q <= printer_d;
      last_q    <= last_d;
      page_q    <= page_d;
      cyc_q     <= cyc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    printer_d = printer_q;
    last_d    = last_q;
    page_d    = page_q;
    cyc_d     = cyc_q;
    page_tick = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state_q)
      // The GAP cycle is the idle cycle itself; its closing edge is the arbitration
      // edge, so back-to-back jobs are separated by exactly one idle cycle.
      ST_IDLE, ST_GAP: begin
        state_d   = ST_IDLE;
        printer_d = PRN_IDLE;
        if (win_valid) begin
          state_d   = ST_PRINT;
          printer_d = win;
          last_d    = win;
          page_d    = (win_pages == '0) ? PAGE_ONE : win_pages;
          cyc_d     = '0;
        end
      end
      ST_PRINT: begin
        if (!owner_ok) begin
          abort     = 1'b1;
          state_d   = ST_GAP;
          printer_d = PRN_IDLE;
          cyc_d     = '0;
        end else if (cyc_q == CYC_LAST) begin
          page_tick = 1'b1;
          cyc_d     = '0;
          if (page_q <= PAGE_ONE) begin
            done      = 1'b1;
            state_d   = ST_GAP;
            printer_d = PRN_IDLE;
            page_d    = '0;
          end else begin
            page_d = page_q - PAGE_ONE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        printer_d = PRN_IDLE;
      end
    endcase
  end

  assign printer = printer_q;
  assign busy    = (printer_q != PRN_IDLE);

endmodule

// File: tb/tb_printer_job_scheduler.sv
// Randomized job-level stimulus with a queue scoreboard; a negedge monitor checks every cycle.
module tb_printer_job_scheduler;

  localparam int unsigned PC = 4;
  localparam int unsigned PW = 4;
  localparam int N_ROUNDS    = 90;

  typedef struct packed {
    logic [1:0] printer;
    logic       busy;
    logic       page_tick;
    logic       done;
    logic       abort;
  } obs_t;

  logic          clk;
  logic          rst;
  logic [2:0]    rq;
  logic [PW-1:0] pg [3];
  logic [1:0]    printer;
  logic          busy, page_tick, done, abort;

  obs_t exp_q[$];
  obs_t act, expv;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  printer_job_scheduler #(.PAGE_CYCLES(PC), .PAGE_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_boss   (rq[0]),
    .req_eng    (rq[1]),
    .req_boy    (rq[2]),
    .pages_boss (pg[0]),
    .pages_eng  (pg[1]),
    .pages_boy  (pg[2]),
    .printer    (printer),
    .busy       (busy),
    .page_tick  (page_tick),
    .done       (done),
    .abort      (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the DUT presents one observation per cycle, compared against the next queued one.
  always @(negedge clk) begin
    if (mon_en) begin
      act = {printer, busy, page_tick, done, abort};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow t=%0t got=%b required=<queued entry>", $time, act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          n_bad++;
          $display("FAIL cycle_obs t=%0t got {prn,busy,tick,done,abort}=%b required=%b",
                   $time, act, expv);
        end
      end
    end
  end

  function automatic obs_t mk(input logic [1:0] p, input logic pt, input logic dn, input logic ab);
    return {p, (p != 2'b00), pt, dn, ab};
  endfunction

  // Round-robin reference: first requester strictly after the last winner (0=boss,1=eng,2=boy).
  function automatic int pick(input logic [2:0] m, input int last);
    int r;
    r = -1;
    for (int k = 1; k <= 3; k++) begin
      if (r < 0 && m[(last + k) % 3]) r = (last + k) % 3;
    end
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    rq = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) pg[i] = PW'($urandom_range(0, 5));
  endtask

  initial begin
    int         last_w;
    int         w, p, total, ab_at, rs_at;
    logic [1:0] code;
    logic [2:0] mask;
    bit         force_be;

    last_w   = 2;
    force_be = 1'b0;
    rst      = 1'b0;
    rq       = 3'b000;
    for (int i = 0; i < 3; i++) pg[i] = '0;

    // reset state, with requests already high while reset is held
    next_cycle();
    rq     = 3'b111;
    mon_en = 1'b1;
    exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0));

    for (int r = 0; r < N_ROUNDS; r++) begin
      // Free cycle: idle or gap; inputs set here are sampled on the grant edge.
      next_cycle();
      rst = 1'b1;
      rand_inputs();
      mask = rq;
      if ($urandom_range(0, 4) == 0) mask = 3'b000;
      if ($urandom_range(0, 5) == 0) mask = 3'b111;
      if (force_be) mask = 3'b011;
      force_be = 1'b0;
      rq = mask;
      exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0));
      if (mask == 3'b000) continue;

      w      = pick(mask, last_w);
      last_w = w;
      code   = 2'(w + 1);
      p      = int'(pg[w]);
      if (p == 0) p = 1;
      total  = p * int'(PC);
      ab_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total)) : 0;
      rs_at  = (ab_at == 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, total)) : 0;

      for (int c = 1; c <= total; c++) begin
        next_cycle();
        rand_inputs();
        rq[w] = 1'b1;
        if (c == rs_at) begin
          rst = 1'b0;
          exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0));
          last_w   = 2;
          force_be = 1'b1;
          break;
        end
        if (c == ab_at) begin
          rq[w] = 1'b0;
          exp_q.push_back(mk(code, 1'b0, 1'b0, 1'b1));
          break;
        end
        exp_q.push_back(mk(code, (c % int'(PC)) == 0, c == total, 1'b0));
      end
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d entries left required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
